// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and defaults for the data-memory responder:
//               FSM state encoding, DEPTH/LATENCY defaults and the byte-offset
//               width of a 32-bit word address.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DEPTH_DEFAULT   = 256;
  localparam int LATENCY_DEFAULT = 2;
  localparam int WORD_OFF_W      = 2;   // byte-offset bits below a 32-bit word index
  localparam int CNT_W           = 4;   // wait counter holds LATENCY 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x 32-bit word storage. Synchronous write, combinational
//               read, asynchronous clear of every word while rst_n is low.
// Ports       : clk_i    - clock
//               rst_n    - asynchronous active-low clear
//               we_i     - write enable
//               waddr_i  - write word index
//               wdata_i  - write data
//               raddr_i  - read word index
//               rdata_o  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory slave for a CPU MEM stage. Accepts one read or
//               write request at a time, inserts LATENCY wait states, then
//               pulses ack_o for one cycle with read data / error status.
// Ports       : clk_i      - clock (rising edge)
//               rst_n      - asynchronous active-low reset
//               req_i      - request strobe
//               MemRead_i  - read qualifier
//               MemWrite_i - write qualifier
//               addr_i     - byte address
//               data_wr_i  - write data
//               ready_o    - high while a new request can be accepted
//               ack_o      - one-cycle response pulse
//               data_rd_o  - read data, non-zero only on a valid read ack
//               err_o      - error flag, valid with ack_o
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_wr_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] data_rd_o,
  output logic        err_o
);

  localparam int             AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    widx_q, widx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rd_ok_q, rd_ok_d;
  logic             wr_ok_q, wr_ok_d;
  logic             err_q, err_d;

  logic             w_accept;
  logic             w_err_in;
  logic             w_enter_resp;
  logic             w_we;
  logic [31:0]      w_rdata;

  assign w_accept = (state_q == ST_IDLE) && req_i && (MemRead_i || MemWrite_i);

  // Misaligned, beyond the array, or ambiguous read+write.
  assign w_err_in = (addr_i[WORD_OFF_W-1:0] != '0)
                 || ({2'b00, addr_i[31:WORD_OFF_W]} >= 32'(DEPTH))
                 || (MemRead_i && MemWrite_i);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    wdata_d      = wdata_q;
    rd_ok_d      = rd_ok_q;
    wr_ok_d      = wr_ok_q;
    err_d        = err_q;
    w_enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          widx_d  = addr_i[AW+WORD_OFF_W-1:WORD_OFF_W];
          wdata_d = data_wr_i;
          rd_ok_d = MemRead_i && !w_err_in;
          wr_ok_d = MemWrite_i && !w_err_in;
          err_d   = w_err_in;
          if (LAT_C == '0) begin
            state_d      = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_C;
          end
        end
      end
      ST_WAIT: begin
        // <= rather than == so a corrupted zero count cannot strand the FSM.
        if (cnt_q <= CNT_W'(1)) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The *_d values are the freshly latched request when LATENCY=0 (write
  // happens on the accept edge) and the held request otherwise.
  assign w_we = w_enter_resp && wr_ok_d;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      rd_ok_q <= 1'b0;
      wr_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rd_ok_q <= rd_ok_d;
      wr_ok_q <= wr_ok_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .we_i    (w_we),
    .waddr_i (widx_d),
    .wdata_i (wdata_d),
    .raddr_i (widx_q),
    .rdata_o (w_rdata)
  );

  assign ready_o   = (state_q == ST_IDLE);
  assign ack_o     = (state_q == ST_RESP);
  assign err_o     = ack_o && err_q;
  assign data_rd_o = (ack_o && rd_ok_q) ? w_rdata : '0;

endmodule : dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait-state cycles inserted before response, legal range 0..15.
REQ-003 The block SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_i  input  1  request strobe from the CPU MEM stage.
REQ-006 The block SHALL have port MemRead_i  input  1  read request qualifier.
REQ-007 The block SHALL have port MemWrite_i  input  1  write request qualifier.
REQ-008 The block SHALL have port addr_i  input  32  byte address.
REQ-009 The block SHALL have port data_wr_i  input  32  write data.
REQ-010 The block SHALL have port ready_o  output  1  high when a new request can be accepted.
REQ-011 The block SHALL have port ack_o  output  1  one-cycle response pulse.
REQ-012 The block SHALL have port data_rd_o  output  32  read data, valid while ack_o is high.
REQ-013 The block SHALL have port err_o  output  1  error flag, valid while ack_o is high.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; ready_o SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where state is IDLE, req_i=1 and (MemRead_i or MemWrite_i)=1; addr_i, data_wr_i, MemRead_i and MemWrite_i SHALL be latched on that edge.
REQ-016 req_i=1 with MemRead_i=0 and MemWrite_i=0 SHALL be ignored; the FSM stays in IDLE and ack_o is not asserted.
REQ-017 On acceptance the FSM SHALL go to WAIT and load a wait counter with LATENCY; with LATENCY=0 it SHALL go directly to RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-019 In RESP ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; acceptance-to-ack latency SHALL be LATENCY+1 cycles.
REQ-020 A request SHALL be an error if addr_i[1:0]!=0, if addr_i[31:2]>=DEPTH, or if MemRead_i and MemWrite_i are both 1.
REQ-021 A valid write SHALL update word addr_i[31:2] on the edge entering RESP; an erroneous write SHALL leave memory unchanged.
REQ-022 On a valid read ack, data_rd_o SHALL equal the stored word; on an error ack, data_rd_o SHALL be 0 and err_o 1; on a write ack, data_rd_o SHALL be 0.
REQ-023 Outside ack cycles, data_rd_o and err_o SHALL be 0.
REQ-024 Inputs SHALL be ignored while ready_o=0; a held req_i SHALL be accepted again only in the IDLE cycle after ack.
REQ-025 A read issued right after a write to the same word SHALL return the newly written data.

Reset
REQ-026 While rst_n=0: state IDLE, counter 0, ready_o=1, ack_o=0, data_rd_o=0, err_o=0, all memory words 0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no memory update and no ack.

Structure
REQ-028 The package dmem_pkg SHALL hold the state enumeration, the DEPTH and LATENCY defaults, and the word-offset width (2).
REQ-029 Storage SHALL be a sub-module dmem_array (DEPTH x 32, synchronous write, combinational read, asynchronous clear); FSM, counter and error decode SHALL stay in dmem_responder.

Verification
REQ-030 Write 0xDEADBEEF to 0x10, then read 0x10, LATENCY=2 -> each ack 3 cycles after acceptance; read ack gives data_rd_o=0xDEADBEEF, err_o=0.
REQ-031 Read from 0x13 (misaligned) -> ack with err_o=1, data_rd_o=0; a following read of 0x10 is unchanged.
REQ-032 Write to 0x400 with DEPTH=256 -> err_o=1; reading word 0 afterwards returns its prior value, proving no alias.
REQ-033 MemRead_i=MemWrite_i=1 at 0x20 -> err_o=1, no write; req_i=1 with both qualifiers 0 -> no ack, ready_o stays 1.
REQ-034 LATENCY=0: back-to-back reads with req_i held high -> ack every 2 cycles, ready_o toggling 1,0.
REQ-035 rst_n pulsed low during WAIT of a write of 0x12345678 to 0x8 -> no ack; a later read of 0x8 returns 0.
